// File: rtl/uart_pkg.sv
// Shared types and helpers for the uart_frame transceiver and its bit timer.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

   localparam int DIV_MIN = 4;

   // Parity bit that makes the data plus this bit even (odd = 0) or odd (odd = 1).
   function automatic logic parity(input logic [7:0] data, input logic odd);
      return (^data) ^ odd;
   endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Loadable down-counter that paces one UART bit; expire is high while the count is 1.
module uart_bit_timer #(
   parameter int DIV_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [DIV_W-1:0] load_val,
   output logic             expire
);

   logic [DIV_W-1:0] count;

   // NOTE: sequential state uses non-blocking assignments and a synchronous reset
   // checked first, so every register sees the same pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (count != '0) begin
         count <= count - DIV_W'(1);
      end
   end

   // A load in the expiry cycle wins, so back-to-back bits need no dead cycle.
   assign expire = (count == DIV_W'(1));

endmodule

// File: rtl/uart_frame.sv
// Full-duplex UART with run-time baud divisor; define UART_PARITY_EN to add a parity bit.
module uart_frame
   import uart_pkg::*;
#(
   parameter int DATA_BITS  = 8,
   parameter int STOP_BITS  = 1,
   parameter int DIV_W      = 16,
   parameter int PARITY_ODD = 0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [DIV_W-1:0]     div,
   input  logic                 rx,
   output logic                 rx_valid,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_perr,
   output logic                 rx_ferr,
   output logic                 tx,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   input  logic [DATA_BITS-1:0] tx_data,
   output logic                 tx_done
);

`ifdef UART_PARITY_EN
   localparam logic PARITY_EN = 1'b1;
`else
   localparam logic PARITY_EN = 1'b0;
`endif

   localparam logic       ODD       = (PARITY_ODD != 0);
   localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
   localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

   // ---------------------------------------------------------------- RX
   logic                 rx_m, rx_s;
   state_t               rx_state, rx_state_d;
   logic [3:0]           rx_bit, rx_bit_d;
   logic [DATA_BITS-1:0] rx_shift, rx_shift_d;
   logic [DIV_W-1:0]     rx_div_q, rx_div_d;
   logic                 rx_pend, rx_pend_d;
   logic                 rx_valid_d, rx_perr_d, rx_ferr_d;
   logic [DATA_BITS-1:0] rx_data_d;
   logic                 rx_load, rx_exp;
   logic [DIV_W-1:0]     rx_load_val;

   // Synchroniser resets to the idle line level so reset never looks like a start bit.
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_m <= 1'b1;
         rx_s <= 1'b1;
      end else begin
         rx_m <= rx;
         rx_s <= rx_m;
      end
   end

   uart_bit_timer #(.DIV_W(DIV_W)) u_rx_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (rx_load),
      .load_val (rx_load_val),
      .expire   (rx_exp)
   );

   // NOTE: every always_comb output gets a default before the case, so no path
   // leaves a variable unassigned and no latch is inferred.
   always_comb begin
      rx_state_d  = rx_state;
      rx_bit_d    = rx_bit;
      rx_shift_d  = rx_shift;
      rx_div_d    = rx_div_q;
      rx_pend_d   = rx_pend;
      rx_valid_d  = 1'b0;
      rx_data_d   = rx_data;
      rx_perr_d   = rx_perr;
      rx_ferr_d   = rx_ferr;
      rx_load     = 1'b0;
      rx_load_val = rx_div_q;
      case (rx_state)
         IDLE: begin
            if (!rx_s) begin
               rx_div_d    = div;
               rx_load     = 1'b1;
               rx_load_val = div >> 1;
               rx_state_d  = START;
            end
         end
         START: begin
            if (rx_exp) begin
               if (rx_s) begin
                  rx_state_d = IDLE;
               end else begin
                  rx_load    = 1'b1;
                  rx_bit_d   = '0;
                  rx_pend_d  = 1'b0;
                  rx_state_d = DATA;
               end
            end
         end
         DATA: begin
            if (rx_exp) begin
               rx_shift_d = {rx_s, rx_shift[DATA_BITS-1:1]};
               rx_load    = 1'b1;
               if (rx_bit == LAST_DATA) begin
                  if (PARITY_EN) rx_state_d = PARITY;
                  else           rx_state_d = STOP;
               end else begin
                  rx_bit_d = rx_bit + 4'd1;
               end
            end
         end
         PARITY: begin
            if (rx_exp) begin
               rx_pend_d  = (parity(8'(rx_shift), 1'b0) ^ rx_s) != ODD;
               rx_load    = 1'b1;
               rx_state_d = STOP;
            end
         end
         STOP: begin
            // Leave on the mid-bit sample so a following start bit is caught early.
            if (rx_exp) begin
               rx_valid_d = 1'b1;
               rx_data_d  = rx_shift;
               rx_perr_d  = rx_pend;
               rx_ferr_d  = !rx_s;
               rx_state_d = IDLE;
            end
         end
         default: rx_state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rx_state <= IDLE;
         rx_bit   <= '0;
         rx_shift <= '0;
         rx_div_q <= '0;
         rx_pend  <= 1'b0;
         rx_valid <= 1'b0;
         rx_data  <= '0;
         rx_perr  <= 1'b0;
         rx_ferr  <= 1'b0;
      end else begin
         rx_state <= rx_state_d;
         rx_bit   <= rx_bit_d;
         rx_shift <= rx_shift_d;
         rx_div_q <= rx_div_d;
         rx_pend  <= rx_pend_d;
         rx_valid <= rx_valid_d;
         rx_data  <= rx_data_d;
         rx_perr  <= rx_perr_d;
         rx_ferr  <= rx_ferr_d;
      end
   end

   // ---------------------------------------------------------------- TX
   state_t               tx_state, tx_state_d;
   logic [3:0]           tx_bit, tx_bit_d;
   logic [DATA_BITS-1:0] tx_shift, tx_shift_d;
   logic [DIV_W-1:0]     tx_div_q, tx_div_d;
   logic                 tx_par, tx_par_d;
   logic                 tx_d, tx_done_d;
   logic                 tx_load, tx_exp;
   logic [DIV_W-1:0]     tx_load_val;

   assign tx_ready = (tx_state == IDLE);

   uart_bit_timer #(.DIV_W(DIV_W)) u_tx_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (tx_load),
      .load_val (tx_load_val),
      .expire   (tx_exp)
   );

   always_comb begin
      tx_state_d  = tx_state;
      tx_bit_d    = tx_bit;
      tx_shift_d  = tx_shift;
      tx_div_d    = tx_div_q;
      tx_par_d    = tx_par;
      tx_d        = tx;
      tx_done_d   = 1'b0;
      tx_load     = 1'b0;
      tx_load_val = tx_div_q;
      case (tx_state)
         IDLE: begin
            tx_d = 1'b1;
            if (tx_valid) begin
               tx_shift_d  = tx_data;
               tx_div_d    = div;
               tx_par_d    = parity(8'(tx_data), ODD);
               tx_d        = 1'b0;
               tx_load     = 1'b1;
               tx_load_val = div;
               tx_state_d  = START;
            end
         end
         START: begin
            if (tx_exp) begin
               tx_d       = tx_shift[0];
               tx_shift_d = tx_shift >> 1;
               tx_bit_d   = '0;
               tx_load    = 1'b1;
               tx_state_d = DATA;
            end
         end
         DATA: begin
            if (tx_exp) begin
               tx_load = 1'b1;
               if (tx_bit == LAST_DATA) begin
                  tx_bit_d = '0;
                  if (PARITY_EN) begin
                     tx_d       = tx_par;
                     tx_state_d = PARITY;
                  end else begin
                     tx_d       = 1'b1;
                     tx_state_d = STOP;
                  end
               end else begin
                  tx_d       = tx_shift[0];
                  tx_shift_d = tx_shift >> 1;
                  tx_bit_d   = tx_bit + 4'd1;
               end
            end
         end
         PARITY: begin
            if (tx_exp) begin
               tx_d       = 1'b1;
               tx_load    = 1'b1;
               tx_state_d = STOP;
            end
         end
         STOP: begin
            if (tx_exp) begin
               if (tx_bit == LAST_STOP) begin
                  tx_done_d  = 1'b1;
                  tx_state_d = IDLE;
               end else begin
                  tx_bit_d = tx_bit + 4'd1;
                  tx_load  = 1'b1;
               end
            end
         end
         default: tx_state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         tx_state <= IDLE;
         tx_bit   <= '0;
         tx_shift <= '0;
         tx_div_q <= '0;
         tx_par   <= 1'b0;
         tx       <= 1'b1;
         tx_done  <= 1'b0;
      end else begin
         tx_state <= tx_state_d;
         tx_bit   <= tx_bit_d;
         tx_shift <= tx_shift_d;
         tx_div_q <= tx_div_d;
         tx_par   <= tx_par_d;
         tx       <= tx_d;
         tx_done  <= tx_done_d;
      end
   end

   // Below DIV_MIN the half-bit start check collapses into the start edge itself.
   assert property (@(posedge clk) disable iff (reset)
                    (tx_valid && tx_ready) |-> (div >= DIV_W'(DIV_MIN)));

endmodule

// File: tb/tb_uart_frame.sv
// Self-checking bench for uart_frame: waveform, loopback scoreboard, glitch, framing, reset.
module tb_uart_frame;
   import uart_pkg::*;

`ifdef UART_PARITY_EN
   localparam int P_BITS = 1;
`else
   localparam int P_BITS = 0;
`endif
   localparam int NB = 10 + P_BITS;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] div = 16'd16;
   logic        rx;
   logic        rx_drv = 1'b1;
   logic        loop_en = 1'b0;
   logic        rx_valid, rx_perr, rx_ferr, tx, tx_ready, tx_done;
   logic [7:0]  rx_data;
   logic        tx_valid = 1'b0;
   logic [7:0]  tx_data = 8'h00;

   always #5 clk = ~clk;
   assign rx = loop_en ? tx : rx_drv;

   uart_frame #(.DATA_BITS(8), .STOP_BITS(1), .DIV_W(16), .PARITY_ODD(0)) dut (
      .clk      (clk),
      .reset    (reset),
      .div      (div),
      .rx       (rx),
      .rx_valid (rx_valid),
      .rx_data  (rx_data),
      .rx_perr  (rx_perr),
      .rx_ferr  (rx_ferr),
      .tx       (tx),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .tx_data  (tx_data),
      .tx_done  (tx_done)
   );

`ifdef UART_PARITY_EN
   logic       p_rx = 1'b1;
   logic       p_rx_valid, p_rx_perr, p_rx_ferr, p_tx, p_tx_ready, p_tx_done;
   logic [6:0] p_rx_data;
   int         p_cnt = 0;
   logic [6:0] p_got_data;
   logic       p_got_perr;

   uart_frame #(.DATA_BITS(7), .STOP_BITS(1), .DIV_W(16), .PARITY_ODD(0)) p_dut (
      .clk      (clk),
      .reset    (reset),
      .div      (div),
      .rx       (p_rx),
      .rx_valid (p_rx_valid),
      .rx_data  (p_rx_data),
      .rx_perr  (p_rx_perr),
      .rx_ferr  (p_rx_ferr),
      .tx       (p_tx),
      .tx_valid (1'b0),
      .tx_ready (p_tx_ready),
      .tx_data  (7'h00),
      .tx_done  (p_tx_done)
   );

   always @(negedge clk) begin
      if (p_rx_valid === 1'b1) begin
         p_cnt++;
         p_got_data = p_rx_data;
         p_got_perr = p_rx_perr;
      end
   end
`endif

   typedef struct packed {
      logic [7:0] data;
      logic       perr;
      logic       ferr;
   } rx_exp_t;

   typedef struct {
      logic [7:0] data;
      int         div;
      bit         poke;
      int         exp_len;
      logic [7:0] exp_data;
   } vec_t;

   rx_exp_t sb[$];
   rx_exp_t got;
   int      errors = 0;
   int      checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Wire image of one 8-bit frame, bit 0 first on the line.
   function automatic logic [11:0] frame8(input logic [7:0] d, input logic stop);
      logic [11:0] f;
      f      = '1;
      f[0]   = 1'b0;
      f[8:1] = d;
      if (P_BITS == 1) begin
         f[9]  = ^d;
         f[10] = stop;
      end else begin
         f[9] = stop;
      end
      return f;
   endfunction

   // Scoreboard consumer: every rx_valid must match the oldest expectation.
   always @(negedge clk) begin
      if (rx_valid === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rx_unexpected_valid: got data %0h with nothing expected", rx_data);
         end else begin
            got = sb.pop_front();
            check("rx_data", {24'd0, rx_data}, {24'd0, got.data});
            check("rx_perr", {31'd0, rx_perr}, {31'd0, got.perr});
            check("rx_ferr", {31'd0, rx_ferr}, {31'd0, got.ferr});
         end
      end
   end

   task automatic send_frame(input logic [7:0] data, input int d, input bit push,
                             input bit poke, input int exp_len, input logic [7:0] exp_data);
      int cyc;
      cyc = 0;
      while (tx_ready !== 1'b1 && cyc < 1000) begin
         @(negedge clk);
         cyc++;
      end
      check("tx_ready_wait", {31'd0, tx_ready}, 32'd1);
      tx_data  = data;
      div      = 16'(d);
      tx_valid = 1'b1;
      if (push) sb.push_back(rx_exp_t'({exp_data, 2'b00}));
      @(negedge clk);
      tx_valid = 1'b0;
      cyc = 1;
      while (tx_done !== 1'b1 && cyc < 20 * d + 50) begin
         if (poke && cyc == 3 * d) div = 16'(d + 3);
         @(negedge clk);
         cyc++;
      end
      check("frame_len", cyc, exp_len);
      div = 16'(d);
   endtask

   task automatic drive_bits(input logic [11:0] bits, input int n, input int d, input bit to_p);
      for (int i = 0; i < n; i++) begin
`ifdef UART_PARITY_EN
         if (to_p) p_rx = bits[i];
         else      rx_drv = bits[i];
`else
         if (!to_p) rx_drv = bits[i];
`endif
         repeat (d) @(negedge clk);
      end
      rx_drv = 1'b1;
`ifdef UART_PARITY_EN
      p_rx = 1'b1;
`endif
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        vecs[5];
      logic [11:0] f;
      logic [7:0]  b2b[3];
      int          bad, early, idx, first, last, dones, base;
      bit          pend;

      vecs[0] = '{8'h5A, 4,  1'b0, NB * 4 + 1,  8'h5A};
      vecs[1] = '{8'h81, 5,  1'b1, NB * 5 + 1,  8'h81};
      vecs[2] = '{8'hC3, 7,  1'b0, NB * 7 + 1,  8'hC3};
      vecs[3] = '{8'h01, 23, 1'b1, NB * 23 + 1, 8'h01};
      vecs[4] = '{8'hA5, 16, 1'b0, NB * 16 + 1, 8'hA5};
      b2b[0] = 8'h00;
      b2b[1] = 8'hFF;
      b2b[2] = 8'h3C;

      // Reset values
      repeat (3) @(negedge clk);
      check("rst_tx",       {31'd0, tx},       32'd1);
      check("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
      check("rst_tx_done",  {31'd0, tx_done},  32'd0);
      check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
      check("rst_rx_data",  {24'd0, rx_data},  32'd0);
      check("rst_rx_perr",  {31'd0, rx_perr},  32'd0);
      check("rst_rx_ferr",  {31'd0, rx_ferr},  32'd0);
      reset = 1'b0;
      @(negedge clk);

      // 0xA5 at div=8: exact line waveform and tx_done position
      f = frame8(8'hA5, 1'b1);
      tx_data = 8'hA5;
      div = 16'd8;
      tx_valid = 1'b1;
      check("a5_ready", {31'd0, tx_ready}, 32'd1);
      bad = 0;
      early = 0;
      for (int c = 1; c <= NB * 8; c++) begin
         @(negedge clk);
         if (c == 1) tx_valid = 1'b0;
         if (tx !== f[(c - 1) / 8]) bad++;
         if (tx_done === 1'b1) early++;
      end
      check("a5_wave_errors", bad, 0);
      check("a5_no_early_done", early, 0);
      @(negedge clk);
      check("a5_done", {31'd0, tx_done}, 32'd1);
      check("a5_ready_with_done", {31'd0, tx_ready}, 32'd1);
      check("a5_tx_idle", {31'd0, tx}, 32'd1);
      @(negedge clk);
      check("a5_done_pulse", {31'd0, tx_done}, 32'd0);

      // Loopback table, including div=DIV_MIN and div changes mid-frame
      loop_en = 1'b1;
      foreach (vecs[i])
         send_frame(vecs[i].data, vecs[i].div, 1'b1, vecs[i].poke, vecs[i].exp_len, vecs[i].exp_data);
      repeat (4) @(negedge clk);
      check("table_sb_drained", sb.size(), 0);

      // Back-to-back with tx_valid held high
      div = 16'd16;
      idx = 0;
      tx_data = b2b[0];
      tx_valid = 1'b1;
      first = -1;
      last = -1;
      dones = 0;
      pend = 1'b0;
      for (int c = 0; c < 2000 && dones < 3; c++) begin
         if (tx_done === 1'b1) begin
            dones++;
            last = c;
         end
         if (tx_valid && tx_ready === 1'b1) begin
            if (first < 0) first = c;
            sb.push_back(rx_exp_t'({tx_data, 2'b00}));
            pend = 1'b1;
         end
         @(negedge clk);
         if (pend) begin
            idx++;
            if (idx < 3) tx_data = b2b[idx];
            else         tx_valid = 1'b0;
            pend = 1'b0;
         end
      end
      tx_valid = 1'b0;
      check("b2b_dones", dones, 3);
      // Each handoff shares the tx_done cycle with the next transfer.
      check("b2b_span", last - first, 3 * (NB * 16 + 1));
      repeat (4) @(negedge clk);
      check("b2b_sb_drained", sb.size(), 0);

      // 3-cycle glitch is rejected
      loop_en = 1'b0;
      rx_drv = 1'b0;
      repeat (3) @(negedge clk);
      rx_drv = 1'b1;
      repeat (60) @(negedge clk);
      check("glitch_rx_idle", {29'd0, dut.rx_state}, {29'd0, IDLE});

      // Framing error: 0x55 with a low stop bit
      sb.push_back(rx_exp_t'({8'h55, 1'b0, 1'b1}));
      drive_bits(frame8(8'h55, 1'b0), NB, 16, 1'b0);
      repeat (40) @(negedge clk);
      check("ferr_sb_drained", sb.size(), 0);
      check("ferr_rx_idle", {29'd0, dut.rx_state}, {29'd0, IDLE});

      // Reset for one cycle during data bit 3, then a clean frame
      loop_en = 1'b1;
      div = 16'd8;
      tx_data = 8'h96;
      tx_valid = 1'b1;
      for (int c = 1; c <= 35; c++) begin
         @(negedge clk);
         if (c == 1) tx_valid = 1'b0;
      end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("rstmid_tx", {31'd0, tx}, 32'd1);
      check("rstmid_ready", {31'd0, tx_ready}, 32'd1);
      early = 0;
      repeat (100) begin
         @(negedge clk);
         if (tx_done === 1'b1) early++;
      end
      check("rstmid_no_done", early, 0);
      send_frame(8'h12, 8, 1'b1, 1'b0, NB * 8 + 1, 8'h12);
      repeat (4) @(negedge clk);
      check("rstmid_sb_drained", sb.size(), 0);
      loop_en = 1'b0;

`ifdef UART_PARITY_EN
      // 7-bit even parity: 0x41 has two ones, so a parity bit of 1 is wrong
      base = p_cnt;
      drive_bits({2'b11, 1'b1, 1'b1, 7'h41, 1'b0}, 10, 16, 1'b1);
      repeat (20) @(negedge clk);
      check("par1_count", p_cnt - base, 1);
      check("par1_data", {25'd0, p_got_data}, 32'h41);
      check("par1_perr", {31'd0, p_got_perr}, 32'd1);
      base = p_cnt;
      drive_bits({2'b11, 1'b1, 1'b0, 7'h41, 1'b0}, 10, 16, 1'b1);
      repeat (20) @(negedge clk);
      check("par0_count", p_cnt - base, 1);
      check("par0_data", {25'd0, p_got_data}, 32'h41);
      check("par0_perr", {31'd0, p_got_perr}, 32'd0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
